julia_dispatcher: RTL and testbench

//  Work dispatcher upstream of the Julia worker array. Scans every pixel of one frame in raster order.

---
 rtl/julia_pkg.sv | 23 ++
 rtl/julia_dispatcher_rr_arbiter.sv | 38 +++
 rtl/julia_dispatcher.sv | 122 ++++++++++++
 tb/tb_julia_dispatcher.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared types and defaults for the Julia work dispatcher.
//   disp_state_t : dispatcher FSM encoding
//   JULIA_*      : default geometry / worker count
//   idx_width()  : index width for an N-entry vector, at least 1 bit
package julia_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } disp_state_t;

    localparam int JULIA_NUM_WORKERS = 4;
    localparam int JULIA_IMG_W       = 640;
    localparam int JULIA_IMG_H       = 480;
    localparam int JULIA_COORD_W     = 10;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/julia_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector
//   ptr         : highest-priority index this cycle (must be < N)
//   grant       : one-hot grant, zero when nothing requests
//   grant_valid : some request was granted
//   grant_idx   : binary index of the granted request
module rr_arbiter
    import julia_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    // Walk the requests starting at ptr and wrapping; first hit wins.
    always_comb begin
        int j;
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant[j]    = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/julia_dispatcher.sv
// Frame work dispatcher for the Julia worker array. Walks every pixel of a
// frame in raster order and hands each one to a free worker via its
// jw_ready / jw_start handshake, then waits for all workers to drain.
//   clk, n_rst   : clock, async active-low reset
//   frame_start  : begin a frame (ignored unless idle)
//   jw_ready     : per-worker ready
//   jw_start     : per-worker start pulse, one-hot or zero
//   job_x, job_y : per-worker latched pixel, worker i at [i*COORD_W +: COORD_W]
//   frame_busy   : frame in progress
//   frame_done   : one-cycle completion pulse
//   jobs_issued  : jobs issued in the current / last frame
module julia_dispatcher
    import julia_pkg::*;
#(
    parameter int NUM_WORKERS = JULIA_NUM_WORKERS,
    parameter int IMG_W       = JULIA_IMG_W,
    parameter int IMG_H       = JULIA_IMG_H,
    parameter int COORD_W     = JULIA_COORD_W
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           frame_start,
    input  logic [NUM_WORKERS-1:0]         jw_ready,
    output logic [NUM_WORKERS-1:0]         jw_start,
    output logic [NUM_WORKERS*COORD_W-1:0] job_x,
    output logic [NUM_WORKERS*COORD_W-1:0] job_y,
    output logic                           frame_busy,
    output logic                           frame_done,
    output logic [31:0]                    jobs_issued
);

    localparam int IDX_W = idx_width(NUM_WORKERS);

    disp_state_t                            state, state_nxt;
    logic [COORD_W-1:0]                     x_q, y_q;
    logic [IDX_W-1:0]                       rr_ptr;
    logic [NUM_WORKERS-1:0][COORD_W-1:0]    job_x_q, job_y_q;

    logic [NUM_WORKERS-1:0] eligible;
    logic [NUM_WORKERS-1:0] grant;
    logic                   grant_valid;
    logic [IDX_W-1:0]       grant_idx;
    logic                   do_grant;
    logic                   x_last, px_last;

    // A worker only drops ready the cycle after it samples start, so the
    // worker started last cycle (jw_start itself) is masked for one cycle.
    assign eligible = jw_ready & ~jw_start;

    rr_arbiter #(.N(NUM_WORKERS), .IDX_W(IDX_W)) u_arb (
        .req         (eligible),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign do_grant = (state == ISSUE) && grant_valid;
    assign x_last   = (x_q == COORD_W'(IMG_W - 1));
    assign px_last  = x_last && (y_q == COORD_W'(IMG_H - 1));

    assign job_x = job_x_q;
    assign job_y = job_y_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (frame_start) state_nxt = ISSUE;
            ISSUE: if (do_grant && px_last) state_nxt = DRAIN;
            // Wait until every worker is back in ready and no start is in flight.
            DRAIN: if ((&jw_ready) && (jw_start == '0)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            jw_start    <= '0;
            job_x_q     <= '0;
            job_y_q     <= '0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            jobs_issued <= '0;
            rr_ptr      <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            state      <= state_nxt;
            jw_start   <= do_grant ? grant : '0;
            frame_busy <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
            frame_done <= (state_nxt == DONE);

            if (state == IDLE && frame_start) begin
                x_q         <= '0;
                y_q         <= '0;
                jobs_issued <= '0;
            end

            if (do_grant) begin
                // Coordinates stay put until the worker's next job.
                for (int i = 0; i < NUM_WORKERS; i++) begin
                    if (grant[i]) begin
                        job_x_q[i] <= x_q;
                        job_y_q[i] <= y_q;
                    end
                end
                jobs_issued <= jobs_issued + 32'd1;
                rr_ptr      <= (grant_idx == IDX_W'(NUM_WORKERS - 1)) ? '0
                                                                    : grant_idx + IDX_W'(1);
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_q + COORD_W'(1);
                end else begin
                    x_q <= x_q + COORD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_julia_dispatcher.sv
// Scoreboard bench for julia_dispatcher: stimulus pushes the raster pixel
// list of each frame; a negedge monitor pops one entry per start and checks
// coordinates, arbitration order, counters and completion timing.
module tb_julia_dispatcher;

    localparam int NW    = 4;
    localparam int W     = 3;
    localparam int H     = 3;
    localparam int CW    = 4;
    localparam int TOTAL = W * H;
    localparam int LAT   = 5;

    logic               clk = 1'b0;
    logic               n_rst;
    logic               frame_start;
    logic [NW-1:0]      jw_ready;
    logic [NW-1:0]      jw_start;
    logic [NW*CW-1:0]   job_x, job_y;
    logic               frame_busy, frame_done;
    logic [31:0]        jobs_issued;

    julia_dispatcher #(.NUM_WORKERS(NW), .IMG_W(W), .IMG_H(H), .COORD_W(CW)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .frame_start (frame_start),
        .jw_ready    (jw_ready),
        .jw_start    (jw_start),
        .job_x       (job_x),
        .job_y       (job_y),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .jobs_issued (jobs_issued)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // scoreboard state
    int  exp_q[$];
    int  pops = 0;
    bit  all_popped = 1'b0;
    bit  done_seen = 1'b1;
    int  tb_ptr = 0;
    int  exp_x[NW];
    int  exp_y[NW];
    int  cyc = 0;
    int  start_cnt = 0, first_cyc = 0, last_cyc = 0;

    // worker model state
    logic [NW-1:0] mready = '0;
    logic [NW-1:0] force_hi = '0, force_lo = '0;
    int            rem[NW];
    bit            stall_last = 1'b0;

    logic [NW-1:0] prev_ready = '0, prev_start = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pre-edge view of inputs and of last cycle's start, as the DUT saw them.
    always @(posedge clk) begin
        prev_ready <= jw_ready;
        prev_start <= jw_start;
    end

    // Worker model: holds ready through the start cycle, busy LAT cycles after.
    always @(negedge clk) begin
        for (int i = 0; i < NW; i++) begin
            if (!n_rst) begin
                rem[i]    = 0;
                mready[i] = 1'b0;
            end else if (jw_start[i]) begin
                rem[i] = (stall_last && job_x[i*CW +: CW] == CW'(W-1)
                                     && job_y[i*CW +: CW] == CW'(H-1)) ? 20 : LAT;
            end else if (rem[i] > 0) begin
                rem[i]    = rem[i] - 1;
                mready[i] = (rem[i] == 0);
            end else begin
                mready[i] = 1'b1;
            end
        end
        jw_ready = (mready | force_hi) & ~force_lo;
    end

    // Monitor
    int            g, eg, p, jj;
    logic [NW-1:0] elig;
    bit            exp_done;
    always @(negedge clk) begin
        cyc++;
        if (!n_rst) begin
            exp_q.delete();
            pops       = 0;
            all_popped = 1'b0;
            done_seen  = 1'b1;
            tb_ptr     = 0;
            for (int i = 0; i < NW; i++) begin
                exp_x[i] = 0;
                exp_y[i] = 0;
            end
        end else begin
            if (jw_start != '0) begin
                chk("start_onehot", $countones(jw_start), 1);
                g = -1;
                for (int i = 0; i < NW; i++) if (jw_start[i] && g < 0) g = i;
                elig = prev_ready & ~prev_start;
                eg = -1;
                for (int k = 0; k < NW; k++) begin
                    jj = (tb_ptr + k) % NW;
                    if (eg < 0 && elig[jj]) eg = jj;
                end
                chk("grant_idx", g, eg);
                tb_ptr = (g + 1) % NW;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: worker %0d started, expected none", g);
                end else begin
                    p = exp_q.pop_front();
                    pops++;
                    exp_x[g] = p % W;
                    exp_y[g] = p / W;
                end
                for (int i = 0; i < NW; i++) begin
                    chk("job_x", job_x[i*CW +: CW], exp_x[i]);
                    chk("job_y", job_y[i*CW +: CW], exp_y[i]);
                end
                chk("jobs_issued", jobs_issued, pops);
                chk("busy_on_start", frame_busy, 1);
                if (start_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                start_cnt++;
            end
            // Done is due one cycle after all pixels are out, no start in
            // flight and every worker ready.
            exp_done = all_popped && (prev_start == '0) && (&prev_ready) && !done_seen;
            if (exp_done || frame_done) begin
                chk("frame_done", frame_done, exp_done);
                if (frame_done) begin
                    chk("jobs_at_done", jobs_issued, TOTAL);
                    chk("busy_at_done", frame_busy, 0);
                    done_seen = 1'b1;
                end
            end
            all_popped = (pops == TOTAL);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_start"}, jw_start, 0);
        chk({tag, "_job_x"}, job_x, 0);
        chk({tag, "_job_y"}, job_y, 0);
        chk({tag, "_busy"}, frame_busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_jobs"}, jobs_issued, 0);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        frame_start = 1'b0;
        #1;
        chk_zero_outputs("reset");
        repeat (3) step();
        n_rst = 1'b1;
        step();
    endtask

    task automatic start_frame();
        for (int i = 0; i < TOTAL; i++) exp_q.push_back(i);
        pops       = 0;
        all_popped = 1'b0;
        done_seen  = 1'b0;
        start_cnt  = 0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done_seen && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL %s_timeout: frame_done not seen within %0d cycles, pops=%0d", name, budget, pops);
        end
        step();
    endtask

    initial begin
        int n;
        n_rst = 1'b1;
        frame_start = 1'b0;
        jw_ready = '0;
        #2;
        do_reset();

        // 1: normal workers, raster order, one done
        start_frame();
        wait_done("basic", 400);
        repeat (3) step();
        chk("idle_busy", frame_busy, 0);
        chk("idle_jobs", jobs_issued, TOTAL);

        // 2: every worker always ready -> one start per cycle, rotating
        force_hi = '1;
        start_frame();
        wait_done("allready", 400);
        chk("allready_span", last_cyc - first_cyc, TOTAL - 1);
        force_hi = '0;
        repeat (LAT + 2) step();

        // 3: only W2 ready -> every other cycle, other slots stay zero
        do_reset();
        force_lo = 4'b1011;
        force_hi = 4'b0100;
        start_frame();
        n = 0;
        while (pops < TOTAL && n < 200) begin
            step();
            n++;
        end
        chk("w2_all_issued", pops, TOTAL);
        chk("w2_span", last_cyc - first_cyc, 2 * (TOTAL - 1));
        force_lo = '0;
        force_hi = '0;
        wait_done("w2only", 400);
        repeat (LAT + 2) step();

        // 5a: frame_start mid-frame is ignored
        start_frame();
        repeat (3) step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        wait_done("ignore_start", 400);
        repeat (LAT + 2) step();

        // 5b: reset mid-frame abandons it with no done
        start_frame();
        repeat (4) step();
        n_rst = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        repeat (2) step();
        n_rst = 1'b1;
        repeat (10) step();
        chk("after_reset_busy", frame_busy, 0);
        chk("after_reset_jobs", jobs_issued, 0);

        // 6: last job stalls; done only after that worker returns
        stall_last = 1'b1;
        start_frame();
        wait_done("stall", 600);
        stall_last = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
